auction_bid_collector: RTL

- Streaming front end for the sealed-bid auction. Bidders submit one (id, bid) pair per cycle over a valid/ready handshake.
- The block assembles the packed bid vector, whose layout matches the combinational auction input: bidder k occupies bits [k*W +: W].
- It tracks the running maximum. Once all 2**N bidders have submitted, it presents the result in the auction output packing: winning bid in the high bits, winner index in the low bits.

---
 rtl/auction_bid_collector.sv | 102 ++++++++++
 1 files changed

// File: rtl/auction_bid_collector.sv
// Streaming sealed-bid collector: gathers one bid per bidder over valid/ready,
// tracks the running maximum, and presents {winning_bid, winner} once all have bid.
module auction_bid_collector #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_id,
    input  logic [W-1:0]         in_bid,
    output logic                 dup_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N+W-1:0]       o,
    output logic [(2**N)*W-1:0]  bids_packed
);

    localparam int unsigned NumBidders = 2 ** N;

    typedef enum logic {StCollect, StDone} state_e;

    state_e                    state_q, state_d;
    logic [NumBidders-1:0]     mask_q, mask_d;
    logic [W-1:0]              max_q, max_d;
    logic [N-1:0]              winner_q, winner_d;
    logic [NumBidders*W-1:0]   bids_q, bids_d;
    logic [N+W-1:0]            o_q, o_d;
    logic                      dup_q, dup_d;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        max_d    = max_q;
        winner_d = winner_q;
        bids_d   = bids_q;
        o_d      = o_q;
        dup_d    = 1'b0;

        unique case (state_q)
            StCollect: begin
                if (in_valid) begin
                    if (mask_q[in_id]) begin
                        // First bid stands; the duplicate is consumed and flagged.
                        dup_d = 1'b1;
                    end else begin
                        mask_d[in_id]        = 1'b1;
                        bids_d[in_id*W +: W] = in_bid;
                        if ((mask_q == '0) || (in_bid > max_q) ||
                            ((in_bid == max_q) && (in_id < winner_q))) begin
                            max_d    = in_bid;
                            winner_d = in_id;
                        end
                        if (&mask_d) begin
                            state_d = StDone;
                            o_d     = {max_d, winner_d};
                        end
                    end
                end
            end
            StDone: begin
                // o keeps the last result after handoff; everything else clears.
                if (out_ready) begin
                    state_d  = StCollect;
                    mask_d   = '0;
                    max_d    = '0;
                    winner_d = '0;
                    bids_d   = '0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StCollect;
            mask_q   <= '0;
            max_q    <= '0;
            winner_q <= '0;
            bids_q   <= '0;
            o_q      <= '0;
            dup_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            max_q    <= max_d;
            winner_q <= winner_d;
            bids_q   <= bids_d;
            o_q      <= o_d;
            dup_q    <= dup_d;
        end
    end

    assign in_ready    = (state_q == StCollect);
    assign out_valid   = (state_q == StDone);
    assign dup_err     = dup_q;
    assign o           = o_q;
    assign bids_packed = bids_q;

endmodule
